// File: rtl/mem_access_tracker.sv
// Passive tracker for a req/gnt/rvalid memory port: keeps granted accesses in an in-order
// pending queue and emits one timestamped trace record per completed access on a valid/ready stream.
module mem_access_tracker #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIME_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DROP_CNT_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mem_req,
    input  logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic                                 mem_gnt,
    input  logic                                 mem_rvalid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    input  logic [TIME_WIDTH-1:0]                counter,
    output logic                                 trace_valid,
    input  logic                                 trace_ready,
    output logic [ADDR_WIDTH-1:0]                trace_addr,
    output logic [DATA_WIDTH-1:0]                trace_data,
    output logic [TIME_WIDTH-1:0]                trace_t_req,
    output logic [TIME_WIDTH-1:0]                trace_t_gnt,
    output logic [TIME_WIDTH-1:0]                trace_t_rvalid,
    output logic [$clog2(MAX_OUTSTANDING):0]     pending_count,
    output logic                                 overflow,
    output logic                                 proto_err,
    output logic [DROP_CNT_WIDTH-1:0]            drop_count
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_GNT
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [TIME_WIDTH-1:0] t_req;
        logic [TIME_WIDTH-1:0] t_gnt;
    } entry_t;

    state_t                  state_reg, state_next;
    logic [TIME_WIDTH-1:0]   t_req_reg, t_req_next;
    logic                    push;
    entry_t                  push_entry;

    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic                    q_empty, q_full;
    logic                    pop, push_ok, push_drop, rvalid_orphan;
    entry_t                  slot_rd [MAX_OUTSTANDING];
    entry_t                  head;

    logic                    out_valid_reg;
    logic [ADDR_WIDTH-1:0]   out_addr_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [TIME_WIDTH-1:0]   out_t_req_reg, out_t_gnt_reg, out_t_rvalid_reg;
    logic                    overflow_reg, proto_err_reg;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg;

    // ------------------------------------------------------------------
    // Request FSM: tracks the request phase up to its grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            t_req_reg <= '0;
        end else begin
            state_reg <= state_next;
            t_req_reg <= t_req_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        t_req_next       = t_req_reg;
        push             = 1'b0;
        push_entry.addr  = mem_addr;
        push_entry.t_req = counter;
        push_entry.t_gnt = counter;
        case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    t_req_next = counter;
                    if (mem_gnt) begin
                        push = 1'b1;
                    end else begin
                        state_next = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                push_entry.t_req = t_req_reg;
                if (mem_gnt) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else if (!mem_req) begin
                    // request withdrawn before grant: nothing to track
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending queue: in-order FIFO of granted, unanswered accesses
    // ------------------------------------------------------------------
    assign q_empty       = (count_reg == '0);
    assign q_full        = (count_reg == DEPTH);
    assign pop           = mem_rvalid && !q_empty;
    assign rvalid_orphan = mem_rvalid && q_empty;
    assign push_ok       = push && (!q_full || pop);
    assign push_drop     = push && q_full && !pop;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Slot storage needs no reset: validity is carried by the pointers and count.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
            entry_t slot_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= push_entry;
                end
            end
            assign slot_rd[gi] = slot_reg;
        end
    endgenerate

    assign head = slot_rd[rd_ptr_reg];

    // ------------------------------------------------------------------
    // One-deep output register and sticky status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_addr_reg     <= '0;
            out_data_reg     <= '0;
            out_t_req_reg    <= '0;
            out_t_gnt_reg    <= '0;
            out_t_rvalid_reg <= '0;
            overflow_reg     <= 1'b0;
            proto_err_reg    <= 1'b0;
            drop_cnt_reg     <= '0;
        end else begin
            if (pop) begin
                if (out_valid_reg && !trace_ready) begin
                    // held record wins; the new one is lost
                    overflow_reg <= 1'b1;
                    if (drop_cnt_reg != '1) begin
                        drop_cnt_reg <= drop_cnt_reg + DROP_CNT_WIDTH'(1);
                    end
                end else begin
                    out_valid_reg    <= 1'b1;
                    out_addr_reg     <= head.addr;
                    out_data_reg     <= mem_rdata;
                    out_t_req_reg    <= head.t_req;
                    out_t_gnt_reg    <= head.t_gnt;
                    out_t_rvalid_reg <= counter;
                end
            end else if (out_valid_reg && trace_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end
            if (rvalid_orphan) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign trace_valid    = out_valid_reg;
    assign trace_addr     = out_addr_reg;
    assign trace_data     = out_data_reg;
    assign trace_t_req    = out_t_req_reg;
    assign trace_t_gnt    = out_t_gnt_reg;
    assign trace_t_rvalid = out_t_rvalid_reg;
    assign pending_count  = count_reg;
    assign overflow       = overflow_reg;
    assign proto_err      = proto_err_reg;
    assign drop_count     = drop_cnt_reg;

endmodule

// File: tb/tb_mem_access_tracker.sv
// Self-checking bench for mem_access_tracker: table-driven vectors plus hand sequences,
// with a scoreboard of expected trace records compared on each stream transfer.
module tb_mem_access_tracker;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TW  = 32;
    localparam int MO  = 4;
    localparam int DCW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [DW-1:0]        mem_rdata;
    logic [TW-1:0]        counter;
    logic                 trace_valid;
    logic                 trace_ready;
    logic [AW-1:0]        trace_addr;
    logic [DW-1:0]        trace_data;
    logic [TW-1:0]        trace_t_req;
    logic [TW-1:0]        trace_t_gnt;
    logic [TW-1:0]        trace_t_rvalid;
    logic [$clog2(MO):0]  pending_count;
    logic                 overflow;
    logic                 proto_err;
    logic [DCW-1:0]       drop_count;

    always #5 clk = ~clk;

    mem_access_tracker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIME_WIDTH(TW),
        .MAX_OUTSTANDING(MO), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .counter(counter),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_t_req(trace_t_req), .trace_t_gnt(trace_t_gnt), .trace_t_rvalid(trace_t_rvalid),
        .pending_count(pending_count), .overflow(overflow), .proto_err(proto_err),
        .drop_count(drop_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] t_req;
        logic [31:0] t_gnt;
        logic [31:0] t_rv;
    } rec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] t_req;
        logic [31:0] t_gnt;
    } pend_t;

    typedef struct {
        logic [31:0] cnt;
        logic        req;
        logic [31:0] addr;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        int          exp_pc;
        logic        exp_tv;
    } vec_t;

    rec_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] got_addr[$];
    rec_t        last_rec;

    logic        m_wait, m_valid, m_ovf, m_perr;
    logic [31:0] m_treq;
    int          m_drops;
    int          checks = 0;
    int          errors = 0;
    vec_t        vt[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        trace_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend_q.delete();
        exp_q.delete();
        m_wait  = 1'b0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
        m_treq  = '0;
        m_drops = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, trace_valid, 0);
        chk({tag, "_addr"}, trace_addr, 0);
        chk({tag, "_data"}, trace_data, 0);
        chk({tag, "_t_req"}, trace_t_req, 0);
        chk({tag, "_t_gnt"}, trace_t_gnt, 0);
        chk({tag, "_t_rvalid"}, trace_t_rvalid, 0);
        chk({tag, "_pending"}, pending_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_proto_err"}, proto_err, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
    endtask

    // One clock cycle: drive inputs, score any transfer, advance the model, check status.
    task automatic step(input logic [31:0] cnt, input logic req, input logic [31:0] addr,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy);
        rec_t  r;
        pend_t p;
        int    pre;
        logic  popped;
        logic  push;
        counter     = cnt;
        mem_req     = req;
        mem_addr    = addr;
        mem_gnt     = gnt;
        mem_rvalid  = rv;
        mem_rdata   = rd;
        trace_ready = rdy;
        if (trace_valid && rdy) begin
            $display("trace addr=%h data=%h t_req=%0d t_gnt=%0d t_rvalid=%0d",
                     trace_addr, trace_data, trace_t_req, trace_t_gnt, trace_t_rvalid);
            got_addr.push_back(trace_addr);
            last_rec = '{trace_addr, trace_data, trace_t_req, trace_t_gnt, trace_t_rvalid};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got addr %h expected no record", trace_addr);
            end else begin
                r = exp_q.pop_front();
                chk("rec_addr", trace_addr, r.addr);
                chk("rec_data", trace_data, r.data);
                chk("rec_t_req", trace_t_req, r.t_req);
                chk("rec_t_gnt", trace_t_gnt, r.t_gnt);
                chk("rec_t_rvalid", trace_t_rvalid, r.t_rv);
            end
        end
        popped = 1'b0;
        push   = 1'b0;
        pre    = pend_q.size();
        if (rv) begin
            if (pre == 0) begin
                m_perr = 1'b1;
            end else begin
                p      = pend_q.pop_front();
                r      = '{p.addr, rd, p.t_req, p.t_gnt, cnt};
                popped = 1'b1;
            end
        end
        if (!m_wait) begin
            if (req) begin
                if (gnt) begin
                    push = 1'b1;
                    p    = '{addr, cnt, cnt};
                end else begin
                    m_wait = 1'b1;
                    m_treq = cnt;
                end
            end
        end else begin
            if (gnt) begin
                push   = 1'b1;
                p      = '{addr, m_treq, cnt};
                m_wait = 1'b0;
            end else if (!req) begin
                m_wait = 1'b0;
            end
        end
        if (push) begin
            if (pre == MO && !popped) m_ovf = 1'b1;
            else pend_q.push_back(p);
        end
        if (popped) begin
            if (m_valid && !rdy) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end else begin
                exp_q.push_back(r);
                m_valid = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("trace_valid", trace_valid, m_valid);
        chk("pending_count", pending_count, pend_q.size());
        chk("overflow", overflow, m_ovf);
        chk("proto_err", proto_err, m_perr);
        chk("drop_count", drop_count, m_drops);
    endtask

    task automatic run_vec(input int i);
        step(vt[i].cnt, vt[i].req, vt[i].addr, vt[i].gnt, vt[i].rv, vt[i].rd, vt[i].rdy);
        chk($sformatf("vec%0d_pending", i), pending_count, vt[i].exp_pc);
        chk($sformatf("vec%0d_valid", i), trace_valid, vt[i].exp_tv);
    endtask

    initial begin
        // cnt, req, addr, gnt, rv, rdata, rdy, pending after edge, trace_valid after edge
        vt[0]  = '{32'd10, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0};
        vt[1]  = '{32'd11, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0};
        vt[2]  = '{32'd12, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0};
        vt[3]  = '{32'd13, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0};
        vt[4]  = '{32'd14, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0};
        vt[5]  = '{32'd15, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 0, 1'b1};
        vt[6]  = '{32'd16, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0};
        vt[7]  = '{32'd20, 1'b1, 32'hA0,  1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0};
        vt[8]  = '{32'd21, 1'b1, 32'hA4,  1'b1, 1'b0, 32'h0, 1'b1, 2, 1'b0};
        vt[9]  = '{32'd22, 1'b1, 32'hA8,  1'b1, 1'b0, 32'h0, 1'b1, 3, 1'b0};
        vt[10] = '{32'd23, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0};
        vt[11] = '{32'd24, 1'b0, 32'h0,   1'b0, 1'b1, 32'h11110000, 1'b1, 2, 1'b1};
        vt[12] = '{32'd25, 1'b0, 32'h0,   1'b0, 1'b1, 32'h22220000, 1'b1, 1, 1'b1};
        vt[13] = '{32'd26, 1'b0, 32'h0,   1'b0, 1'b1, 32'h33330000, 1'b1, 0, 1'b1};
        vt[14] = '{32'd27, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0};

        counter = '0;
        do_reset();
        check_all_zero("reset");

        // single access through WAIT_GNT
        for (int i = 0; i < 7; i++) run_vec(i);
        chk("single_addr", last_rec.addr, 32'h100);
        chk("single_data", last_rec.data, 32'hDEADBEEF);
        chk("single_t_req", last_rec.t_req, 10);
        chk("single_t_gnt", last_rec.t_gnt, 12);
        chk("single_t_rvalid", last_rec.t_rv, 15);

        // pipelined grants
        got_addr.delete();
        for (int i = 7; i < 15; i++) run_vec(i);
        chk("pipe_count", got_addr.size(), 3);
        for (int i = 0; i < got_addr.size(); i++)
            chk($sformatf("pipe_addr%0d", i), got_addr[i], 32'hA0 + 32'(4 * i));

        // queue full: fifth grant discarded
        got_addr.delete();
        for (int i = 0; i < 5; i++) step(32'(40 + i), 1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b1);
        chk("full_pending", pending_count, 4);
        chk("full_overflow", overflow, 1);
        step(32'd45, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(32'(46 + i), 1'b0, 32'h0, 1'b0, 1'b1, 32'h5000 + 32'(i), 1'b1);
        step(32'd50, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("full_count", got_addr.size(), 4);
        for (int i = 0; i < got_addr.size(); i++)
            chk($sformatf("full_addr%0d", i), got_addr[i], 32'h200 + 32'(4 * i));

        // backpressure: held record, two drops, then release with a same-cycle load
        do_reset();
        for (int i = 0; i < 4; i++) step(32'(60 + i), 1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'(64 + i), 1'b0, 32'h0, 1'b0, 1'b1, 32'h6000 + 32'(i), 1'b0);
        chk("bp_drop_count", drop_count, 2);
        chk("bp_overflow", overflow, 1);
        chk("bp_held_valid", trace_valid, 1);
        chk("bp_held_addr", trace_addr, 32'h300);
        chk("bp_held_data", trace_data, 32'h6000);
        got_addr.delete();
        step(32'd67, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6003, 1'b1);
        step(32'd68, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_count", got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            chk("bp_first", got_addr[0], 32'h300);
            chk("bp_fourth", got_addr[1], 32'h30C);
        end
        chk("bp_drop_final", drop_count, 2);

        // protocol errors
        do_reset();
        step(32'd70, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55, 1'b1);
        chk("perr_flag", proto_err, 1);
        chk("perr_no_valid", trace_valid, 0);
        do_reset();
        step(32'd72, 1'b1, 32'h400, 1'b1, 1'b1, 32'h66, 1'b1);
        chk("perr_gnt_flag", proto_err, 1);
        chk("perr_gnt_pending", pending_count, 1);
        step(32'd73, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b1);
        step(32'd74, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("perr_rec_addr", last_rec.addr, 32'h400);
        chk("perr_rec_t_rvalid", last_rec.t_rv, 73);

        // reset with accesses in flight and a held record
        do_reset();
        for (int i = 0; i < 3; i++) step(32'(80 + i), 1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 32'h0, 1'b0);
        step(32'd83, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000, 1'b0);
        chk("mid_pending", pending_count, 2);
        chk("mid_valid", trace_valid, 1);
        do_reset();
        check_all_zero("midrst");
        step(32'd90, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b1);
        step(32'd91, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(32'd92, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
        step(32'd93, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("clean_addr", last_rec.addr, 32'h600);
        chk("clean_data", last_rec.data, 32'hCAFEF00D);
        chk("clean_t_req", last_rec.t_req, 90);
        chk("clean_t_gnt", last_rec.t_gnt, 90);
        chk("clean_t_rvalid", last_rec.t_rv, 92);

        // request withdrawn before grant leaves nothing pending
        step(32'd95, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 1'b1);
        step(32'd96, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(32'd97, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("withdrawn_pending", pending_count, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_tracker.md
Name: mem_access_tracker

Overview:
- Parametrised successor to the single-outstanding IF tracker; passively snoops a req/gnt/rvalid memory port (instruction or data side) and emits one trace record per completed access.
- Supports up to MAX_OUTSTANDING granted-but-unanswered accesses, held in an in-order pending queue.
- Records timestamps from the shared trace counter; output is a valid/ready stream consumed by the trace buffer.

Parameters:
ADDR_WIDTH, 32, width of snooped address
DATA_WIDTH, 32, width of snooped read data
TIME_WIDTH, 32, width of timestamp counter input and timestamp fields
MAX_OUTSTANDING, 4, pending-queue depth (power of 2, >=2)
DROP_CNT_WIDTH, 8, width of saturating dropped-record counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
mem_req  input  1  snooped request
mem_addr  input  ADDR_WIDTH  snooped address
mem_gnt  input  1  snooped grant
mem_rvalid  input  1  snooped response valid
mem_rdata  input  DATA_WIDTH  snooped response data
counter  input  TIME_WIDTH  global trace timestamp
trace_valid  output  1  record available
trace_ready  input  1  consumer accepts record
trace_addr  output  ADDR_WIDTH  record address
trace_data  output  DATA_WIDTH  record read data
trace_t_req  output  TIME_WIDTH  first cycle of mem_req
trace_t_gnt  output  TIME_WIDTH  grant cycle
trace_t_rvalid  output  TIME_WIDTH  response cycle
pending_count  output  $clog2(MAX_OUTSTANDING)+1  entries in pending queue
overflow  output  1  sticky: record dropped or pending queue overrun
proto_err  output  1  sticky: rvalid with empty pending queue
drop_count  output  DROP_CNT_WIDTH  saturating count of dropped records

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0, queue empty, FSM IDLE; applies mid-access, in-flight accesses discarded, no record emitted for them.
- Request FSM, states IDLE, WAIT_GNT:
  - IDLE & mem_req: latch t_req=counter. If mem_gnt same cycle, push {mem_addr, t_req=t_gnt=counter}, stay IDLE; else go WAIT_GNT.
  - WAIT_GNT & mem_gnt: push {mem_addr, latched t_req, t_gnt=counter}, go IDLE.
  - mem_req held high after a grant cycle starts a new request in the next cycle (t_req = next cycle's counter).
  - mem_req dropping in WAIT_GNT without grant: return to IDLE, nothing pushed.
- Pending queue: in-order FIFO, depth MAX_OUTSTANDING, pointers wrap modulo depth.
  - Push with queue full (and no pop same cycle): entry discarded, overflow=1.
  - Push and pop in the same cycle, including when full: both succeed, count unchanged.
- Completion: mem_rvalid pops the oldest entry and forms a record with trace_data=mem_rdata and trace_t_rvalid=counter.
  - mem_rvalid with empty queue and no same-cycle push: proto_err=1, ignored.
  - mem_rvalid with empty queue plus a same-cycle push (gnt and rvalid in one cycle): proto_err=1, push proceeds, rvalid ignored.
- Output register, one deep:
  - A record formed in cycle N appears with trace_valid=1 at cycle N+1.
  - Fields stay stable while trace_valid & !trace_ready.
  - Transfer occurs on trace_valid & trace_ready; trace_valid clears the next cycle unless a new record is loaded.
  - New record while trace_valid & !trace_ready: new record dropped, overflow=1, drop_count+1 (saturates at all-ones). Held record unchanged.
  - New record in the same cycle as a transfer: loaded, no drop.
- Timestamps are raw counter copies; no arithmetic, no wrap correction.
- overflow and proto_err clear only on rst.

Test Plan:
- Single access: req at counter=10, gnt at 12, rvalid at 15 with addr 0x100, data 0xDEADBEEF, trace_ready=1 -> one record {0x100, 0xDEADBEEF, 10, 12, 15}, trace_valid high only at counter 16.
- Pipelined: 3 grants at counters 20, 21, 22 (addrs A0/A4/A8), rvalids at 24/25/26 -> 3 in-order records; pending_count peaks at 3.
- Queue full: MAX_OUTSTANDING=4, 5 grants with no rvalid -> overflow=1, pending_count=4, the 4 rvalids yield the first 4 addrs only.
- Backpressure: trace_ready=0, 3 completions -> first record held, drop_count=2, overflow=1. Raising trace_ready in the cycle of a 4th completion -> no drop, 4th record follows.
- Protocol error: rvalid with empty queue -> proto_err=1, no trace_valid. Gnt and rvalid in the same cycle on an empty queue -> proto_err=1, pending_count=1.
- Reset mid-flight: 2 pending plus a held record, rst for 1 cycle -> all outputs 0. A later clean access traces correctly.
